// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ==========================================================================
// pipe_hazard_ctrl : PC / IF_ID / ID_RR / RR_EX enable and clear sequencing
// Revision 1.0
// ==========================================================================
module pipe_hazard_ctrl (
  input  logic       clk,
  input  logic       RST_N,
  input  logic [2:0] RR_SRC_A,
  input  logic [2:0] RR_SRC_B,
  input  logic       RR_USES_A,
  input  logic       RR_USES_B,
  input  logic       RR_IS_MULTI,
  input  logic [7:0] RR_LIST,
  input  logic [2:0] EX_DEST,
  input  logic       EX_IS_LOAD,
  input  logic       EX_REDIRECT,
  output logic       PC_EN,
  output logic       IF_ID_EN,
  output logic       ID_RR_EN,
  output logic       RR_EX_EN,
  output logic       IF_ID_CLR,
  output logic       ID_RR_CLR,
  output logic       RR_EX_CLR,
  output logic       MULTI_ACTIVE,
  output logic [2:0] MULTI_REG,
  output logic [2:0] MULTI_IDX
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_FLUSH  = 2'd1;
  localparam logic [1:0] ST_BUBBLE = 2'd2;
  localparam logic [1:0] ST_MULTI  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [7:0] rem_q, rem_d;
  logic [2:0] cnt_q, cnt_d;
  logic       if_id_clr_q, id_rr_clr_q, rr_ex_clr_q;

  logic       haz;
  logic       multi_go;
  logic       list_last;
  logic       rem_last;

  function automatic logic [2:0] lowest_bit(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  assign haz = EX_IS_LOAD && ((RR_USES_A && (RR_SRC_A == EX_DEST)) ||
                              (RR_USES_B && (RR_SRC_B == EX_DEST)));
  assign multi_go  = RR_IS_MULTI && (RR_LIST != 8'd0);
  // "last" covers zero or one set bit, so a stray empty REM cannot wedge MULTI
  assign list_last = ~|(RR_LIST & (RR_LIST - 8'd1));
  assign rem_last  = ~|(rem_q & (rem_q - 8'd1));

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_FLUSH;
      rem_q       <= 8'd0;
      cnt_q       <= 3'd0;
      if_id_clr_q <= 1'b1;
      id_rr_clr_q <= 1'b1;
      rr_ex_clr_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      if_id_clr_q <= (state_d == ST_FLUSH);
      id_rr_clr_q <= (state_d == ST_FLUSH);
      rr_ex_clr_q <= (state_d == ST_FLUSH) || (state_d == ST_BUBBLE);
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (EX_REDIRECT) begin
          state_d = ST_FLUSH;
        end else if (haz) begin
          state_d = ST_BUBBLE;
        end else if (multi_go && !list_last) begin
          rem_d   = RR_LIST & (RR_LIST - 8'd1);
          cnt_d   = 3'd1;
          state_d = ST_MULTI;
        end
      end
      ST_FLUSH:  state_d = ST_RUN;
      ST_BUBBLE: state_d = ST_RUN;
      ST_MULTI: begin
        if (EX_REDIRECT) begin
          rem_d   = 8'd0;
          cnt_d   = 3'd0;
          state_d = ST_FLUSH;
        end else if (rem_last) begin
          rem_d   = 8'd0;
          cnt_d   = 3'd0;
          state_d = ST_RUN;
        end else begin
          rem_d   = rem_q & (rem_q - 8'd1);
          cnt_d   = cnt_q + 3'd1;
        end
      end
      default: state_d = ST_FLUSH;
    endcase
  end

  always_comb begin
    PC_EN        = 1'b0;
    IF_ID_EN     = 1'b0;
    ID_RR_EN     = 1'b0;
    RR_EX_EN     = 1'b0;
    MULTI_ACTIVE = 1'b0;
    MULTI_REG    = 3'd0;
    MULTI_IDX    = 3'd0;
    case (state_q)
      ST_RUN: begin
        if (EX_REDIRECT) begin
          {PC_EN, IF_ID_EN, ID_RR_EN, RR_EX_EN} = 4'hF;
        end else if (haz) begin
          {PC_EN, IF_ID_EN, ID_RR_EN, RR_EX_EN} = 4'h0;
        end else if (multi_go) begin
          MULTI_ACTIVE = 1'b1;
          MULTI_REG    = lowest_bit(RR_LIST);
          RR_EX_EN     = 1'b1;
          {PC_EN, IF_ID_EN, ID_RR_EN} = {3{list_last}};
        end else begin
          {PC_EN, IF_ID_EN, ID_RR_EN, RR_EX_EN} = 4'hF;
        end
      end
      ST_MULTI: begin
        // A redirect abandons the sequence; the wrong-path RR slot is flushed next
        if (EX_REDIRECT) begin
          {PC_EN, IF_ID_EN, ID_RR_EN, RR_EX_EN} = 4'hF;
        end else begin
          MULTI_ACTIVE = 1'b1;
          MULTI_REG    = lowest_bit(rem_q);
          MULTI_IDX    = cnt_q;
          RR_EX_EN     = 1'b1;
          {PC_EN, IF_ID_EN, ID_RR_EN} = {3{rem_last}};
        end
      end
      default: ;
    endcase
  end

  assign IF_ID_CLR = if_id_clr_q;
  assign ID_RR_CLR = id_rr_clr_q;
  assign RR_EX_CLR = rr_ex_clr_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_pipe_hazard_ctrl : scoreboard bench with a queue-based reference model
// Revision 1.0
// ==========================================================================
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       RST_N;
  logic [2:0] RR_SRC_A, RR_SRC_B, EX_DEST;
  logic       RR_USES_A, RR_USES_B, RR_IS_MULTI, EX_IS_LOAD, EX_REDIRECT;
  logic [7:0] RR_LIST;
  logic       PC_EN, IF_ID_EN, ID_RR_EN, RR_EX_EN;
  logic       IF_ID_CLR, ID_RR_CLR, RR_EX_CLR;
  logic       MULTI_ACTIVE;
  logic [2:0] MULTI_REG, MULTI_IDX;

  pipe_hazard_ctrl dut (
    .clk(clk), .RST_N(RST_N),
    .RR_SRC_A(RR_SRC_A), .RR_SRC_B(RR_SRC_B),
    .RR_USES_A(RR_USES_A), .RR_USES_B(RR_USES_B),
    .RR_IS_MULTI(RR_IS_MULTI), .RR_LIST(RR_LIST),
    .EX_DEST(EX_DEST), .EX_IS_LOAD(EX_IS_LOAD), .EX_REDIRECT(EX_REDIRECT),
    .PC_EN(PC_EN), .IF_ID_EN(IF_ID_EN), .ID_RR_EN(ID_RR_EN), .RR_EX_EN(RR_EX_EN),
    .IF_ID_CLR(IF_ID_CLR), .ID_RR_CLR(ID_RR_CLR), .RR_EX_CLR(RR_EX_CLR),
    .MULTI_ACTIVE(MULTI_ACTIVE), .MULTI_REG(MULTI_REG), .MULTI_IDX(MULTI_IDX)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] exp;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_cycle  = 0;

  // Reference model: pending flush/bubble flags plus a queue of registers
  // still to be transferred for the current LM/SM.
  bit   m_flush  = 1'b0;
  bit   m_bubble = 1'b0;
  int   m_q[$];
  int   m_idx    = 0;

  wire [13:0] act = {PC_EN, IF_ID_EN, ID_RR_EN, RR_EX_EN,
                     IF_ID_CLR, ID_RR_CLR, RR_EX_CLR,
                     MULTI_ACTIVE, MULTI_REG, MULTI_IDX};

  exp_t mon_e;
  always @(negedge clk) begin
    n_cycle++;
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      n_checks++;
      if (act !== mon_e.exp) begin
        n_fail++;
        $display("FAIL %s (cycle %0d): en/clr/act/reg/idx got %b_%b_%b_%b_%b required %b_%b_%b_%b_%b",
                 mon_e.name, n_cycle,
                 act[13:10], act[9:7], act[6], act[5:3], act[2:0],
                 mon_e.exp[13:10], mon_e.exp[9:7], mon_e.exp[6], mon_e.exp[5:3], mon_e.exp[2:0]);
      end
    end
  end

  task automatic push_expect(input string name);
    logic [3:0] en;
    logic [2:0] clr;
    logic       ma;
    logic [2:0] rg, ix;
    bit         haz;
    en = 4'h0; clr = 3'b000; ma = 1'b0; rg = 3'd0; ix = 3'd0;
    haz = EX_IS_LOAD && ((RR_USES_A && RR_SRC_A == EX_DEST) ||
                         (RR_USES_B && RR_SRC_B == EX_DEST));
    if (!RST_N) begin
      clr = 3'b111; m_flush = 1'b1; m_bubble = 1'b0; m_q.delete();
    end else if (m_flush) begin
      clr = 3'b111; m_flush = 1'b0;
    end else if (m_bubble) begin
      clr = 3'b001; m_bubble = 1'b0;
    end else if (m_q.size() > 0) begin
      if (EX_REDIRECT) begin
        en = 4'hF; m_q.delete(); m_flush = 1'b1;
      end else begin
        ma = 1'b1; rg = 3'(m_q.pop_front()); ix = 3'(m_idx); m_idx++;
        en = (m_q.size() == 0) ? 4'hF : 4'h1;
      end
    end else begin
      if (EX_REDIRECT) begin
        en = 4'hF; m_flush = 1'b1;
      end else if (haz) begin
        m_bubble = 1'b1;
      end else if (RR_IS_MULTI && RR_LIST != 8'd0) begin
        for (int i = 0; i < 8; i++) if (RR_LIST[i]) m_q.push_back(i);
        m_idx = 0;
        ma = 1'b1; rg = 3'(m_q.pop_front()); ix = 3'(m_idx); m_idx++;
        en = (m_q.size() == 0) ? 4'hF : 4'h1;
      end else begin
        en = 4'hF;
      end
    end
    sbq.push_back('{exp: {en, clr, ma, rg, ix}, name: name});
  endtask

  task automatic step(input string name);
    push_expect(name);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RR_SRC_A = 3'd0; RR_SRC_B = 3'd0; RR_USES_A = 1'b0; RR_USES_B = 1'b0;
    RR_IS_MULTI = 1'b0; RR_LIST = 8'd0; EX_DEST = 3'd0;
    EX_IS_LOAD = 1'b0; EX_REDIRECT = 1'b0;
  endtask

  task automatic rand_inputs();
    RR_SRC_A    = 3'($urandom_range(0, 7));
    RR_SRC_B    = 3'($urandom_range(0, 7));
    RR_USES_A   = 1'($urandom_range(0, 1));
    RR_USES_B   = 1'($urandom_range(0, 1));
    EX_DEST     = 3'($urandom_range(0, 7));
    EX_IS_LOAD  = ($urandom_range(0, 2) == 0);
    EX_REDIRECT = ($urandom_range(0, 9) == 0);
    RR_IS_MULTI = ($urandom_range(0, 3) == 0);
    case ($urandom_range(0, 3))
      0:       RR_LIST = 8'd0;
      1:       RR_LIST = 8'(1 << $urandom_range(0, 7));
      default: RR_LIST = 8'($urandom);
    endcase
  endtask

  initial begin
    idle();
    RST_N = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      step("reset_hold");
    end
    idle();
    RST_N = 1'b1;
    step("reset_release_flush");
    step("reset_run0");
    step("reset_run1");

    EX_IS_LOAD = 1'b1; EX_DEST = 3'd3; RR_USES_B = 1'b1; RR_SRC_B = 3'd3;
    step("loaduse_stall");
    step("loaduse_bubble");
    idle();
    step("loaduse_resume");

    EX_IS_LOAD = 1'b1; EX_DEST = 3'd5; RR_USES_A = 1'b1; RR_SRC_A = 3'd5;
    RR_IS_MULTI = 1'b1; RR_LIST = 8'hA6; EX_REDIRECT = 1'b1;
    step("redirect_priority");
    idle();
    step("redirect_flush");
    step("redirect_resume");

    RR_IS_MULTI = 1'b1; RR_LIST = 8'hA6;
    for (int i = 0; i < 4; i++) step("lm_a6");
    idle();
    step("lm_a6_after");

    RR_IS_MULTI = 1'b1; RR_LIST = 8'h80;
    step("lm_single_80");
    RR_LIST = 8'h00;
    step("lm_empty_list");
    idle();

    RR_IS_MULTI = 1'b1; RR_LIST = 8'hFF;
    step("lm_ff_t0");
    idle();
    step("lm_ff_t1");
    RST_N = 1'b0;
    step("lm_ff_reset");
    step("lm_ff_reset_hold");
    RST_N = 1'b1;
    step("lm_ff_release_flush");
    for (int i = 0; i < 3; i++) step("lm_ff_no_residue");

    RR_IS_MULTI = 1'b1; RR_LIST = 8'hFF;
    for (int i = 0; i < 8; i++) step("lm_ff_full");
    idle();
    step("lm_ff_full_after");

    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      RST_N = ($urandom_range(0, 99) != 0);
      step("random");
    end
    RST_N = 1'b1;
    idle();
    step("final");

    @(negedge clk);
    #1;
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
